// File: rtl/lut_ctrl_pkg.sv
// Shared types and sizes for the lut_1596 sweep controller.
package lut_ctrl_pkg;

  localparam int LUT_W = 4;
  localparam int LUT_DEPTH = 2**LUT_W;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} sweep_state_t;

endpackage

// File: rtl/lut_1596.sv
// 4-input lookup table lut_1596: output is high for input codes 4, 8 and 10.
module lut_1596
  import lut_ctrl_pkg::*;
(
  input  logic [LUT_W-1:0] x,
  output logic             y
);

  localparam logic [LUT_DEPTH-1:0] TABLE = 16'h0510;

  assign y = TABLE[x];

endmodule

// File: rtl/lut_sweep_ctrl.sv
// Exhaustive sweep of lut_1596: drives every input code once, captures the output
// mask and derives hit count, lowest hit index and a compare against an expected mask.
module lut_sweep_ctrl
  import lut_ctrl_pkg::*;
#(
  parameter int W = LUT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [2**W-1:0]   exp_mask,
  output logic [W-1:0]      x,
  output logic              busy,
  output logic              done,
  output logic [2**W-1:0]   result,
  output logic              result_valid,
  output logic [W:0]        hit_cnt,
  output logic [W-1:0]      first_hit,
  output logic              any_hit,
  output logic              match
);

  localparam int D = 2**W;
  localparam logic [W-1:0] LAST    = '1;
  localparam logic [W-1:0] ONE_IDX = 1;
  localparam logic [W:0]   ONE_CNT = 1;

  sweep_state_t   state;
  logic [W-1:0]   index;
  logic           y;
  logic [D-1:0]   result_nxt;

  lut_1596 u_lut (
    .x (index),
    .y (y)
  );

  // Index is parked at 0 outside SCAN, so it doubles as the registered x output.
  assign x = index;

  always_comb begin
    result_nxt        = result;
    result_nxt[index] = y;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      index        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      hit_cnt      <= '0;
      first_hit    <= '0;
      any_hit      <= 1'b0;
      match        <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state        <= SCAN;
            busy         <= 1'b1;
            index        <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            hit_cnt      <= '0;
            first_hit    <= '0;
            any_hit      <= 1'b0;
            match        <= 1'b0;
          end
        end
        SCAN: begin
          // Abort wins over everything, including completion on the last code.
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            index <= '0;
          end else begin
            result <= result_nxt;
            if (y) begin
              hit_cnt <= hit_cnt + ONE_CNT;
              if (!any_hit) begin
                first_hit <= index;
                any_hit   <= 1'b1;
              end
            end
            if (index == LAST) begin
              state        <= DONE;
              busy         <= 1'b0;
              index        <= '0;
              done         <= 1'b1;
              result_valid <= 1'b1;
              match        <= (result_nxt == exp_mask);
            end else begin
              index <= index + ONE_IDX;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lut_sweep_ctrl.sv
// Scoreboard bench for lut_sweep_ctrl: driver pushes expected scan outcomes, monitor
// pops and compares on every done pulse; directed plan followed by randomized traffic.
module tb_lut_sweep_ctrl;
  import lut_ctrl_pkg::*;

  localparam int W = 4;
  localparam int D = 16;

  logic          clk = 1'b0;
  logic          rst, start, abort;
  logic [D-1:0]  exp_mask;
  logic [W-1:0]  x;
  logic          busy, done, result_valid, any_hit, match;
  logic [D-1:0]  result;
  logic [W:0]    hit_cnt;
  logic [W-1:0]  first_hit;

  lut_sweep_ctrl #(.W(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .exp_mask     (exp_mask),
    .x            (x),
    .busy         (busy),
    .done         (done),
    .result       (result),
    .result_valid (result_valid),
    .hit_cnt      (hit_cnt),
    .first_hit    (first_hit),
    .any_hit      (any_hit),
    .match        (match)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] res;
    int          hits;
    int          first;
    bit          mt;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference LUT: the set of codes for which lut_1596 outputs 1.
  function automatic bit ref_lut(int code);
    return (code == 4) || (code == 8) || (code == 10);
  endfunction

  function automatic exp_t ref_scan(logic [15:0] em);
    exp_t e;
    e.res   = '0;
    e.hits  = 0;
    e.first = -1;
    for (int c = 0; c < D; c++) begin
      if (ref_lut(c)) begin
        e.res[c] = 1'b1;
        e.hits++;
        if (e.first < 0) e.first = c;
      end
    end
    if (e.first < 0) e.first = 0;
    e.mt = (e.res == em);
    return e;
  endfunction

  function automatic int ref_hits_below(int k);
    int n = 0;
    for (int c = 0; c < k; c++) if (ref_lut(c)) n++;
    return n;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_x"}, 32'(x), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_result"}, 32'(result), 0);
    check({tag, "_result_valid"}, 32'(result_valid), 0);
    check({tag, "_hit_cnt"}, 32'(hit_cnt), 0);
    check({tag, "_first_hit"}, 32'(first_hit), 0);
    check({tag, "_any_hit"}, 32'(any_hit), 0);
    check({tag, "_match"}, 32'(match), 0);
  endtask

  // Monitor: every done pulse must correspond to an expected completed scan.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_done: got done=1, required no pending scan at %0t", $time);
      end else begin
        mon_e = sb_q.pop_front();
        check("mon_result", 32'(result), 32'(mon_e.res));
        check("mon_hit_cnt", 32'(hit_cnt), mon_e.hits);
        check("mon_first_hit", 32'(first_hit), mon_e.first);
        check("mon_any_hit", 32'(any_hit), 32'(mon_e.hits != 0));
        check("mon_match", 32'(match), 32'(mon_e.mt));
        check("mon_result_valid", 32'(result_valid), 1);
        check("mon_busy", 32'(busy), 0);
      end
    end
  end

  // Entry: somewhere before a rising edge with the DUT idle. Returns mid-cycle, DUT idle.
  task automatic run_scan(input logic [15:0] em, input int abort_at, input int rst_at,
                          input bit strays);
    exp_t e;
    e        = ref_scan(em);
    start    = 1'b1;
    abort    = 1'($urandom_range(0, 1));
    exp_mask = em;
    if (abort_at < 0 && rst_at < 0) sb_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    for (int k = 0; k < D; k++) begin
      if (k == abort_at) abort = 1'b1;
      if (k == rst_at) rst = 1'b1;
      if (strays) start = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      check("scan_x", 32'(x), k);
      check("scan_busy", 32'(busy), 1);
      check("scan_result_valid", 32'(result_valid), 0);
      @(posedge clk); #1;
      abort = 1'b0;
      start = 1'b0;
      if (k == abort_at) begin
        @(negedge clk);
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_result_valid", 32'(result_valid), 0);
        check("abort_x", 32'(x), 0);
        check("abort_hit_cnt", 32'(hit_cnt), ref_hits_below(k));
        return;
      end
      if (k == rst_at) begin
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("midrst");
        return;
      end
    end
    // Done cycle: a start here must be ignored.
    if (strays) start = 1'($urandom_range(0, 1));
    @(negedge clk);
    check("done_cycle_done", 32'(done), 1);
    check("done_cycle_x", 32'(x), 0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("idle_done", 32'(done), 0);
    check("idle_busy", 32'(busy), 0);
    check("idle_result_valid", 32'(result_valid), 1);
    check("idle_result_hold", 32'(result), 32'(e.res));
    check("idle_match_hold", 32'(match), 32'(e.mt));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      start = 1'b0;
      abort = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk);
      check("gap_busy", 32'(busy), 0);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int mode, ab;
    logic [15:0] em;
    rst      = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    exp_mask = '0;
    @(posedge clk); @(posedge clk); #1;
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    run_scan(16'h0510, -1, -1, 1'b0);
    run_scan(16'h0511, -1, -1, 1'b0);
    idle(2);
    run_scan(16'h0510, 6, -1, 1'b0);
    run_scan(16'h0510, -1, -1, 1'b0);
    // Back-to-back: start re-asserted in the first idle cycle after each done.
    run_scan(16'h0510, -1, -1, 1'b0);
    run_scan(16'h0000, -1, -1, 1'b0);
    run_scan(16'h0510, -1, -1, 1'b0);
    idle(1);
    run_scan(16'h0510, -1, 9, 1'b0);
    run_scan(16'h0510, -1, -1, 1'b0);
    run_scan(16'h0510, 15, -1, 1'b0);
    run_scan(16'h0510, -1, -1, 1'b1);

    for (int t = 0; t < 40; t++) begin
      em   = ($urandom_range(0, 1) == 0) ? 16'h0510 : 16'($urandom);
      mode = $urandom_range(0, 7);
      ab   = $urandom_range(0, 15);
      if (ref_lut(ab)) ab++;
      if (mode == 6) run_scan(em, ab, -1, 1'($urandom_range(0, 1)));
      else if (mode == 7) run_scan(em, -1, $urandom_range(0, 15), 1'($urandom_range(0, 1)));
      else run_scan(em, -1, -1, 1'($urandom_range(0, 1)));
      idle($urandom_range(0, 2));
    end

    idle(3);
    check("scoreboard_empty", 32'(sb_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
